// File: rtl/seq_det_pkg.sv
// Shared definitions for the parameterised serial sequence detector:
// FSM state encoding and the pattern-length clamp used at configuration time.
package seq_det_pkg;

   // Two-state controller: unconfigured (ignore the stream) and running.
   typedef enum logic {
      ST_UNCFG = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   // Map a requested pattern length onto the legal range 1..max_len.
   // A length of zero is treated as a single-bit pattern.
   function automatic int unsigned clamp_len(input int unsigned len,
                                             input int unsigned max_len);
      if (len == 0) begin
         return 1;
      end else if (len > max_len) begin
         return max_len;
      end else begin
         return len;
      end
   endfunction

endpackage

// File: rtl/seq_detector_param_if.sv
// Bundle of configuration, stream and status signals for seq_detector_param.
// The master side drives configuration and serial data; the slave side is
// the detector itself.
interface seq_detector_param_if #(
   parameter int MAX_LEN = 8,
   parameter int LEN_W   = $clog2(MAX_LEN + 1),
   parameter int CNT_W   = 8
);
   logic               cfg_load;
   logic [MAX_LEN-1:0] pattern;
   logic [LEN_W-1:0]   pat_len;
   logic               overlap;
   logic               en;
   logic               w;
   logic               cnt_clr;
   logic               z;
   logic [CNT_W-1:0]   match_cnt;
   logic               cnt_sat;
   logic               cfg_valid;

   modport master (
      output cfg_load, pattern, pat_len, overlap, en, w, cnt_clr,
      input  z, match_cnt, cnt_sat, cfg_valid
   );

   modport slave (
      input  cfg_load, pattern, pat_len, overlap, en, w, cnt_clr,
      output z, match_cnt, cnt_sat, cfg_valid
   );
endinterface

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter with a synchronous clear that beats increment.
// Reused outside the detector, so it carries its own width parameter.
module sat_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] count,
   output logic             sat
);

   logic [CNT_W-1:0] count_reg;
   logic [CNT_W-1:0] count_next;

   // Next count: clear first, otherwise step up unless already at all-ones.
   always_comb begin
      count_next = count_reg;
      if (clr) begin
         count_next = '0;
      end else if (inc && !(&count_reg)) begin
         count_next = count_reg + CNT_W'(1);
      end
   end

   // Count register, cleared by the asynchronous reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_next;
      end
   end

   assign count = count_reg;
   assign sat   = &count_reg;

endmodule

// File: rtl/seq_detector_param.sv
// Moore-style serial sequence detector with a run-time programmable pattern
// of 1..MAX_LEN bits, overlap / non-overlap modes, an enable qualifier on the
// stream and a saturating match counter. z is registered: it rises in the
// cycle after the edge that sampled the final pattern bit.
module seq_detector_param
   import seq_det_pkg::*;
#(
   parameter int MAX_LEN = 8,
   parameter int LEN_W   = $clog2(MAX_LEN + 1),
   parameter int CNT_W   = 8
) (
   input logic                 clk,
   input logic                 reset_n,
   seq_detector_param_if.slave bus
);

   state_t             state_reg;
   state_t             state_next;
   logic [MAX_LEN-1:0] hist_reg;
   logic [MAX_LEN-1:0] hist_next;
   logic [LEN_W-1:0]   fill_reg;
   logic [LEN_W-1:0]   fill_next;
   logic [MAX_LEN-1:0] pat_reg;
   logic [MAX_LEN-1:0] pat_next;
   logic [LEN_W-1:0]   len_reg;
   logic [LEN_W-1:0]   len_next;
   logic               ovl_reg;
   logic               ovl_next;
   logic               z_reg;
   logic               z_next;
   logic               cfg_valid_reg;
   logic               cfg_valid_next;

   logic [MAX_LEN-1:0] hist_shift;
   logic [MAX_LEN-1:0] len_mask;
   logic [LEN_W:0]     fill_plus;
   logic [LEN_W-1:0]   len_clamped;
   logic               sample;
   logic               full_enough;
   logic               bits_equal;
   logic               match;

   // History as it would look after shifting in the current bit; the
   // newest bit lands in position 0, matching pattern[0] being last.
   assign hist_shift = {hist_reg[MAX_LEN-2:0], bus.w};

   // Only the low len bits of history and pattern take part in the compare;
   // pattern bits above len-1 are don't-care.
   genvar gi;
   generate
      for (gi = 0; gi < MAX_LEN; gi++) begin : g_len_mask
         assign len_mask[gi] = ({1'b0, len_reg} > (LEN_W + 1)'(gi));
      end
   endgenerate

   assign len_clamped = LEN_W'(clamp_len(32'(bus.pat_len), MAX_LEN));
   assign fill_plus   = {1'b0, fill_reg} + (LEN_W + 1)'(1);

   // A bit is consumed only while running, enabled, and not reconfiguring.
   assign sample      = (state_reg == ST_RUN) && bus.en && !bus.cfg_load;
   assign full_enough = (fill_plus >= {1'b0, len_reg});
   assign bits_equal  = (((hist_shift ^ pat_reg) & len_mask) == '0);
   assign match       = sample && full_enough && bits_equal;

   // Next-state and datapath: config load wins over sampling; an idle or
   // disabled cycle holds history and fill but drops z.
   always_comb begin
      state_next     = state_reg;
      hist_next      = hist_reg;
      fill_next      = fill_reg;
      pat_next       = pat_reg;
      len_next       = len_reg;
      ovl_next       = ovl_reg;
      cfg_valid_next = cfg_valid_reg;
      z_next         = 1'b0;

      case (state_reg)
         ST_UNCFG: begin
            if (bus.cfg_load) begin
               state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            state_next = ST_RUN;
         end
         default: begin
            state_next = ST_UNCFG;
         end
      endcase

      if (bus.cfg_load) begin
         pat_next       = bus.pattern;
         len_next       = len_clamped;
         ovl_next       = bus.overlap;
         hist_next      = '0;
         fill_next      = '0;
         cfg_valid_next = 1'b1;
      end else if (sample) begin
         hist_next = hist_shift;
         if (full_enough) begin
            fill_next = len_reg;
         end else begin
            fill_next = fill_plus[LEN_W-1:0];
         end
         // Non-overlapping mode demands a fresh len bits after each hit.
         if (match && !ovl_reg) begin
            fill_next = '0;
         end
         z_next = match;
      end
   end

   // State, configuration and history registers with asynchronous reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg     <= ST_UNCFG;
         hist_reg      <= '0;
         fill_reg      <= '0;
         pat_reg       <= '0;
         len_reg       <= LEN_W'(1);
         ovl_reg       <= 1'b0;
         z_reg         <= 1'b0;
         cfg_valid_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         hist_reg      <= hist_next;
         fill_reg      <= fill_next;
         pat_reg       <= pat_next;
         len_reg       <= len_next;
         ovl_reg       <= ovl_next;
         z_reg         <= z_next;
         cfg_valid_reg <= cfg_valid_next;
      end
   end

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_match_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (match),
      .clr     (bus.cnt_clr),
      .count   (bus.match_cnt),
      .sat     (bus.cnt_sat)
   );

   assign bus.z         = z_reg;
   assign bus.cfg_valid = cfg_valid_reg;

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench for seq_detector_param: directed scenarios plus a
// randomized run compared against a queue-based model of the detector.
module tb_seq_detector_param;

   logic clk;
   logic reset_n;

   seq_detector_param_if #(.MAX_LEN(8), .CNT_W(8)) b8 ();
   seq_detector_param_if #(.MAX_LEN(8), .CNT_W(4)) b4 ();

   seq_detector_param #(.MAX_LEN(8), .CNT_W(8)) dut8 (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (b8.slave)
   );

   seq_detector_param #(.MAX_LEN(8), .CNT_W(4)) dut4 (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (b4.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   // Reference model for dut8: the bits received since the last restart of
   // matching, trimmed to the pattern length.
   bit       m_q[$];
   bit       m_cfg;
   int       m_len;
   logic [7:0] m_pat;
   bit       m_ovl;
   bit       m_z;
   int       m_cnt;

   function automatic void model_reset();
      m_q.delete();
      m_cfg = 0;
      m_len = 1;
      m_pat = 8'h00;
      m_ovl = 0;
      m_z   = 0;
      m_cnt = 0;
   endfunction

   function automatic void model_step(input logic cl, input logic [7:0] pat,
                                      input logic [3:0] plen, input logic ov,
                                      input logic e, input logic wb,
                                      input logic clr);
      bit hit;
      hit = 0;
      if (cl) begin
         m_cfg = 1;
         m_len = (plen == 0) ? 1 : ((plen > 8) ? 8 : int'(plen));
         m_pat = pat;
         m_ovl = ov;
         m_q.delete();
      end else if (m_cfg && e) begin
         m_q.push_back(wb);
         while (m_q.size() > m_len) void'(m_q.pop_front());
         if (m_q.size() == m_len) begin
            hit = 1;
            for (int i = 0; i < m_len; i++)
               if (m_q[i] != m_pat[m_len-1-i]) hit = 0;
         end
         if (hit && !m_ovl) m_q.delete();
      end
      m_z = hit;
      if (clr) m_cnt = 0;
      else if (hit && m_cnt < 255) m_cnt = m_cnt + 1;
   endfunction

   task automatic set8(input logic cl, input logic [7:0] pat, input logic [3:0] plen,
                       input logic ov, input logic e, input logic wb, input logic clr);
      b8.cfg_load = cl; b8.pattern = pat; b8.pat_len = plen; b8.overlap = ov;
      b8.en = e; b8.w = wb; b8.cnt_clr = clr;
   endtask

   task automatic set4(input logic cl, input logic [7:0] pat, input logic [3:0] plen,
                       input logic ov, input logic e, input logic wb, input logic clr);
      b4.cfg_load = cl; b4.pattern = pat; b4.pat_len = plen; b4.overlap = ov;
      b4.en = e; b4.w = wb; b4.cnt_clr = clr;
   endtask

   // One clock: advance the model with the inputs presented, then sample #1 after the edge.
   task automatic cyc();
      model_step(b8.cfg_load, b8.pattern, b8.pat_len, b8.overlap, b8.en, b8.w, b8.cnt_clr);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #2;
      chk_cnt++; if (b8.z !== 1'b0) $display("FAIL reset_z8 got %b want 0", b8.z); else pass_cnt++;
      chk_cnt++; if (b8.match_cnt !== 8'd0) $display("FAIL reset_cnt8 got %0d want 0", b8.match_cnt); else pass_cnt++;
      chk_cnt++; if (b8.cnt_sat !== 1'b0) $display("FAIL reset_sat8 got %b want 0", b8.cnt_sat); else pass_cnt++;
      chk_cnt++; if (b8.cfg_valid !== 1'b0) $display("FAIL reset_cfgv8 got %b want 0", b8.cfg_valid); else pass_cnt++;
      chk_cnt++; if (b4.match_cnt !== 4'd0) $display("FAIL reset_cnt4 got %0d want 0", b4.match_cnt); else pass_cnt++;
      chk_cnt++; if (b4.cnt_sat !== 1'b0) $display("FAIL reset_sat4 got %b want 0", b4.cnt_sat); else pass_cnt++;
      @(negedge clk);
      reset_n = 1'b1;
      cyc();
      $display("reset: released, outputs checked");
   endtask

   task automatic test_uncfg();
      for (int i = 0; i < 3; i++) begin
         set8(0, 8'h07, 4'd3, 1, 1, 1, 0);
         cyc();
         chk_cnt++; if (b8.z !== 1'b0) $display("FAIL uncfg_z got %b want 0 bit %0d", b8.z, i); else pass_cnt++;
         chk_cnt++; if (b8.cfg_valid !== 1'b0) $display("FAIL uncfg_cfgv got %b want 0 bit %0d", b8.cfg_valid, i); else pass_cnt++;
      end
      $display("uncfg: stream 111 ignored before cfg_load");
   endtask

   task automatic test_1001(input logic ov, input logic [6:0] expz, input int expcnt);
      logic [6:0] stream;
      stream = 7'b1001001;
      set8(1, 8'b1001, 4'd4, ov, 1, 1, 1);
      cyc();
      chk_cnt++; if (b8.cfg_valid !== 1'b1) $display("FAIL p1001_cfgv got %b want 1", b8.cfg_valid); else pass_cnt++;
      chk_cnt++; if (b8.z !== 1'b0) $display("FAIL p1001_cfgz got %b want 0", b8.z); else pass_cnt++;
      for (int i = 0; i < 7; i++) begin
         set8(0, 8'b1001, 4'd4, ov, 1, stream[6-i], 0);
         cyc();
         chk_cnt++;
         if (b8.z !== expz[6-i]) $display("FAIL p1001_z ov=%b bit %0d got %b want %b", ov, i + 1, b8.z, expz[6-i]);
         else pass_cnt++;
      end
      chk_cnt++;
      if (b8.match_cnt !== 8'(expcnt)) $display("FAIL p1001_cnt ov=%b got %0d want %0d", ov, b8.match_cnt, expcnt);
      else pass_cnt++;
      $display("pattern 1001 overlap=%b: stream 1001001 count %0d", ov, b8.match_cnt);
   endtask

   task automatic test_back_to_back(input logic ov, input logic [3:0] expz, input int expcnt);
      set8(1, 8'b11, 4'd2, ov, 0, 0, 1);
      cyc();
      for (int i = 0; i < 4; i++) begin
         set8(0, 8'b11, 4'd2, ov, 1, 1, 0);
         cyc();
         chk_cnt++;
         if (b8.z !== expz[3-i]) $display("FAIL p11_z ov=%b bit %0d got %b want %b", ov, i + 1, b8.z, expz[3-i]);
         else pass_cnt++;
      end
      chk_cnt++;
      if (b8.match_cnt !== 8'(expcnt)) $display("FAIL p11_cnt ov=%b got %0d want %0d", ov, b8.match_cnt, expcnt);
      else pass_cnt++;
      $display("pattern 11 overlap=%b: stream 1111 count %0d", ov, b8.match_cnt);
   endtask

   task automatic test_en_gap();
      set8(1, 8'b101, 4'd3, 1, 0, 0, 1);
      cyc();
      set8(0, 8'b101, 4'd3, 1, 1, 1, 0); cyc();
      chk_cnt++; if (b8.z !== 1'b0) $display("FAIL gap_z1 got %b want 0", b8.z); else pass_cnt++;
      set8(0, 8'b101, 4'd3, 1, 1, 0, 0); cyc();
      chk_cnt++; if (b8.z !== 1'b0) $display("FAIL gap_z2 got %b want 0", b8.z); else pass_cnt++;
      for (int i = 0; i < 3; i++) begin
         set8(0, 8'b101, 4'd3, 1, 0, 1, 0); cyc();
         chk_cnt++; if (b8.z !== 1'b0) $display("FAIL gap_hold got %b want 0 cycle %0d", b8.z, i); else pass_cnt++;
      end
      set8(0, 8'b101, 4'd3, 1, 1, 1, 0); cyc();
      chk_cnt++; if (b8.z !== 1'b1) $display("FAIL gap_final got %b want 1", b8.z); else pass_cnt++;
      set8(0, 8'b101, 4'd3, 1, 0, 0, 0); cyc();
      chk_cnt++; if (b8.z !== 1'b0) $display("FAIL gap_after got %b want 0", b8.z); else pass_cnt++;
      chk_cnt++; if (b8.match_cnt !== 8'd1) $display("FAIL gap_cnt got %0d want 1", b8.match_cnt); else pass_cnt++;
      $display("en gap: 10 <gap> 1 gives one match");
   endtask

   task automatic test_reset_midstream();
      logic [5:0] stream;
      stream = 6'b100100;
      set8(1, 8'b1001, 4'd4, 1, 0, 0, 1);
      cyc();
      for (int i = 0; i < 6; i++) begin
         set8(0, 8'b1001, 4'd4, 1, 1, stream[5-i], 0);
         cyc();
      end
      chk_cnt++; if (b8.match_cnt !== 8'd1) $display("FAIL mid_precnt got %0d want 1", b8.match_cnt); else pass_cnt++;
      set8(0, 8'b1001, 4'd4, 1, 0, 0, 0);
      #3 reset_n = 1'b0;
      model_reset();
      #1;
      chk_cnt++; if (b8.z !== 1'b0) $display("FAIL mid_rst_z got %b want 0", b8.z); else pass_cnt++;
      chk_cnt++; if (b8.match_cnt !== 8'd0) $display("FAIL mid_rst_cnt got %0d want 0", b8.match_cnt); else pass_cnt++;
      chk_cnt++; if (b8.cnt_sat !== 1'b0) $display("FAIL mid_rst_sat got %b want 0", b8.cnt_sat); else pass_cnt++;
      chk_cnt++; if (b8.cfg_valid !== 1'b0) $display("FAIL mid_rst_cfgv got %b want 0", b8.cfg_valid); else pass_cnt++;
      @(negedge clk);
      reset_n = 1'b1;
      set8(1, 8'b1001, 4'd4, 1, 0, 0, 0);
      cyc();
      set8(0, 8'b1001, 4'd4, 1, 1, 1, 0);
      cyc();
      chk_cnt++; if (b8.z !== 1'b0) $display("FAIL mid_z got %b want 0", b8.z); else pass_cnt++;
      chk_cnt++; if (b8.match_cnt !== 8'd0) $display("FAIL mid_cnt got %0d want 0", b8.match_cnt); else pass_cnt++;
      $display("midstream reset: partial history discarded");
   endtask

   task automatic test_saturate();
      set8(0, 8'h00, 4'd1, 0, 0, 0, 0);
      set4(1, 8'b0000_0001, 4'd1, 1, 0, 0, 0);
      cyc();
      for (int i = 0; i < 20; i++) begin
         set4(0, 8'b0000_0001, 4'd1, 1, 1, 1, 0);
         cyc();
         chk_cnt++; if (b4.z !== 1'b1) $display("FAIL sat_z got %b want 1 cycle %0d", b4.z, i); else pass_cnt++;
         chk_cnt++;
         if (b4.match_cnt !== 4'((i + 1 > 15) ? 15 : i + 1))
            $display("FAIL sat_cnt got %0d want %0d cycle %0d", b4.match_cnt, (i + 1 > 15) ? 15 : i + 1, i);
         else pass_cnt++;
      end
      chk_cnt++; if (b4.cnt_sat !== 1'b1) $display("FAIL sat_flag got %b want 1", b4.cnt_sat); else pass_cnt++;
      set4(0, 8'b0000_0001, 4'd1, 1, 1, 1, 1);
      cyc();
      chk_cnt++; if (b4.z !== 1'b1) $display("FAIL clr_z got %b want 1", b4.z); else pass_cnt++;
      chk_cnt++; if (b4.match_cnt !== 4'd0) $display("FAIL clr_cnt got %0d want 0", b4.match_cnt); else pass_cnt++;
      chk_cnt++; if (b4.cnt_sat !== 1'b0) $display("FAIL clr_sat got %b want 0", b4.cnt_sat); else pass_cnt++;
      set4(0, 8'b0000_0001, 4'd1, 1, 1, 1, 0);
      cyc();
      chk_cnt++; if (b4.match_cnt !== 4'd1) $display("FAIL clr_next got %0d want 1", b4.match_cnt); else pass_cnt++;
      // Length 0 acts as length 1: pattern bit 0 is 0, so only w=0 hits.
      set4(1, 8'b0000_0010, 4'd0, 1, 0, 0, 0);
      cyc();
      set4(0, 8'b0000_0010, 4'd0, 1, 1, 0, 0);
      cyc();
      chk_cnt++; if (b4.z !== 1'b1) $display("FAIL len0_hit got %b want 1", b4.z); else pass_cnt++;
      set4(0, 8'b0000_0010, 4'd0, 1, 1, 1, 0);
      cyc();
      chk_cnt++; if (b4.z !== 1'b0) $display("FAIL len0_miss got %b want 0", b4.z); else pass_cnt++;
      set4(0, 8'h00, 4'd1, 0, 0, 0, 0);
      $display("saturation: count held at 15, clear and len=0 checked");
   endtask

   task automatic test_random();
      logic [7:0] pat;
      logic [3:0] plen;
      logic       ov;
      int         eff;
      int         ptr;
      logic       wb;
      for (int r = 0; r < 8; r++) begin
         pat  = 8'($urandom);
         plen = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 4));
         ov   = 1'($urandom);
         eff  = (plen == 0) ? 1 : ((plen > 8) ? 8 : int'(plen));
         ptr  = eff - 1;
         set8(1, pat, plen, ov, 1'($urandom), 1'($urandom), 1'($urandom));
         cyc();
         for (int c = 0; c < 60; c++) begin
            if ($urandom_range(0, 1) == 0) wb = pat[ptr];
            else wb = 1'($urandom);
            ptr = (ptr == 0) ? eff - 1 : ptr - 1;
            set8(($urandom_range(0, 49) == 0), pat, plen, ov,
                 ($urandom_range(0, 3) != 0), wb, ($urandom_range(0, 29) == 0));
            cyc();
            chk_cnt++; if (b8.z !== m_z) $display("FAIL rnd_z round %0d cycle %0d got %b want %b", r, c, b8.z, m_z); else pass_cnt++;
            chk_cnt++; if (b8.match_cnt !== 8'(m_cnt)) $display("FAIL rnd_cnt round %0d cycle %0d got %0d want %0d", r, c, b8.match_cnt, m_cnt); else pass_cnt++;
            chk_cnt++; if (b8.cnt_sat !== (m_cnt == 255)) $display("FAIL rnd_sat round %0d cycle %0d got %b", r, c, b8.cnt_sat); else pass_cnt++;
            chk_cnt++; if (b8.cfg_valid !== m_cfg) $display("FAIL rnd_cfgv round %0d cycle %0d got %b want %b", r, c, b8.cfg_valid, m_cfg); else pass_cnt++;
         end
         $display("random round %0d: pat=%b len=%0d ovl=%b count %0d", r, pat, plen, ov, b8.match_cnt);
      end
   endtask

   initial begin
      reset_n = 1'b0;
      model_reset();
      set8(0, 8'h00, 4'd1, 0, 0, 0, 0);
      set4(0, 8'h00, 4'd1, 0, 0, 0, 0);
      test_reset();
      test_uncfg();
      test_1001(1'b1, 7'b0001001, 2);
      test_1001(1'b0, 7'b0001000, 1);
      test_back_to_back(1'b1, 4'b0111, 3);
      test_back_to_back(1'b0, 4'b0101, 2);
      test_en_gap();
      test_reset_midstream();
      test_saturate();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Generalised Moore-style serial sequence detector; successor to the team's fixed-pattern detectors.
- Serial bit stream `w` is compared against a run-time programmable pattern of 1..MAX_LEN bits.
- Supports overlapping and non-overlapping match modes, a stream-enable qualifier, and a saturating match counter.
- Sits after serial front-end logic; `z` and `match_cnt` feed status/interrupt logic.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (>=2).
- LEN_W, $clog2(MAX_LEN+1), width of pat_len.
- CNT_W, 8, width of match counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cfg_load  in  1  latch pattern/pat_len/overlap this cycle.
- pattern  in  MAX_LEN  pattern bits; pattern[pat_len-1] is the first bit received, pattern[0] the last.
- pat_len  in  LEN_W  pattern length; 0 is treated as 1; values above MAX_LEN are clamped to MAX_LEN.
- overlap  in  1  1 = overlapping matches allowed, 0 = non-overlapping.
- en  in  1  w is sampled only when en=1.
- w  in  1  serial data bit.
- cnt_clr  in  1  synchronous clear of match_cnt.
- z  out  1  registered match pulse.
- match_cnt  out  CNT_W  number of matches, saturating.
- cnt_sat  out  1  match_cnt is at all-ones.
- cfg_valid  out  1  a configuration has been loaded since reset.

Behaviour:
- Reset (reset_n=0, asynchronous): state=UNCFG; history, fill, z, match_cnt, cnt_sat and cfg_valid all 0; the config registers go to pattern=0 and len=1. Reset asserted mid-stream discards all partial history.
- FSM has two states, UNCFG and RUN.
  - UNCFG: w is ignored and z=0. cfg_load moves to RUN.
  - RUN: detection active. cfg_load stays in RUN and reloads the config.
- cfg_load cycle:
  - Latch pattern, clamped len, and overlap.
  - Clear history and fill; z<=0.
  - w in the same cycle is ignored, even if en=1 (cfg_load wins).
  - cfg_valid<=1.
- Sampling (RUN, en=1, cfg_load=0):
  - hist <= {hist[MAX_LEN-2:0], w}.
  - fill <= min(fill+1, len).
  - match = (fill+1 >= len) and (new_hist[len-1:0] == pattern[len-1:0]).
  - z <= match. z is high during the cycle following the edge that sampled the last pattern bit, i.e. one cycle of latency, the same Moore timing as the existing detectors.
- Overlap mode: history is kept after a match. Back-to-back matches give z high on consecutive cycles.
- Non-overlap mode: on a match, fill<=0. The next match needs len fresh bits.
- en=0 in RUN: hist and fill hold; z<=0. A gap in en does not break a partial match.
- Counter:
  - On each cycle where match is true, match_cnt <= match_cnt+1, saturating at 2^CNT_W-1.
  - cnt_sat = (match_cnt == all-ones).
  - cnt_clr sets match_cnt<=0 and has priority over a simultaneous match. z still asserts; that match is not counted.
- Pattern bits above len-1 are don't-care.

Decomposition:
- Shared package seq_det_pkg holds:
  - the state encoding localparams ST_UNCFG, ST_RUN;
  - a length-clamp function (0->1, >MAX_LEN->MAX_LEN).
- One sub-module: sat_counter (CNT_W parameter; inputs inc and clr with clr priority; outputs count and sat). The team reuses it elsewhere.

Test Plan:
1. Pattern 1001, len=4, overlap=1, en=1; stream 1,0,0,1,0,0,1 -> z high in the cycle after bit 4 and after bit 7; match_cnt=2.
2. Same stream with overlap=0 -> z high only after bit 4; match_cnt=1.
3. Pattern 11, len=2, overlap=1; stream 1,1,1,1 -> z high for 3 consecutive cycles; match_cnt=3. With overlap=0 -> z pulses after bits 2 and 4; match_cnt=2.
4. Pattern 101, len=3:
   - feed 1,0; then en=0 for 3 cycles with w=1; then en=1 with w=1 -> exactly one z pulse, after the final bit; z=0 throughout the gap.
   - Before any cfg_load, stream 1,1,1 -> z=0 and cfg_valid=0.
5. Pattern 1001; feed 1,0,0; pulse reset_n low mid-cycle; release; cfg_load; feed 1 -> no z; match_cnt=0; all outputs 0 during reset.
6. CNT_W=4, pattern 1, len=1, overlap=1; 20 cycles of w=1 -> match_cnt=15, cnt_sat=1.
   - Then cnt_clr together with a match -> match_cnt=0, z=1.
   - pat_len=0 behaves as len=1.
